// File: rtl/jetson_spi_link.sv
// jetson_spi_link: SPI mode-0 slave for the Jetson command link, with a reply FIFO and on-demand count frames.
// Optional JETSON_LINK_STATS_EN adds a saturating frame-error counter reported in count frames.
module jetson_spi_link #(
    parameter int FIFO_AW     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        spi_cs_n,
    input  logic        cnt_req,
    output logic        irq,
    output logic        rx_valid,
    output logic [3:0]  rx_id,
    output logic [27:0] rx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [3:0]  tx_id,
    input  logic [27:0] tx_data,
    output logic        frame_err
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SEL_NOP, SEL_HEAD, SEL_CNT} sel_t;
    state_t state, state_n;
    sel_t sel, sel_n;
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0] s;
    logic [2:0] s_d;
    logic sclk_rise, sclk_fall, cs_fall, req_edge;
    logic is_load, is_shift, done_ok, done_err, push, pop, cnt_flag;
    logic [5:0] bitcnt;
    logic [31:0] rx_sr, tx_sr, word, cnt_word, occ32, head;
    logic [7:0] occ8;
    logic [15:0] stats;
    logic [FIFO_AW:0] wr_ptr, rd_ptr, occ, occ_n;
    logic [31:0] mem [1<<FIFO_AW];
`ifdef JETSON_LINK_STATS_EN
    logic [15:0] err_cnt, err_snap;
`endif

    // Synchronisers are left unreset so a reset inside a frame cannot fake a cs_n fall.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], spi_sclk, spi_mosi, spi_cs_n, cnt_req};
        s_d    <= {s[3], s[1:0]};
    end

    always_comb begin
        s         = sync_q[SYNC_STAGES-1];
        sclk_rise = s[3] & ~s_d[2];
        sclk_fall = ~s[3] & s_d[2];
        cs_fall   = ~s[1] & s_d[1];
        req_edge  = s[0] ^ s_d[0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  state_n = cs_fall ? LOAD : IDLE;
            LOAD:  state_n = SHIFT;
            SHIFT: state_n = s[1] ? DONE : SHIFT;
            DONE:  state_n = cs_fall ? LOAD : IDLE;
        endcase
    end

    always_comb begin
        is_load  = state == LOAD;
        is_shift = state == SHIFT;
        done_ok  = state == DONE && bitcnt == 6'd32;
        done_err = state == DONE && bitcnt != 6'd32;
    end

    always_comb begin
        push  = tx_valid & tx_ready;
        pop   = done_ok && sel == SEL_HEAD;
        occ   = wr_ptr - rd_ptr;
        occ_n = occ + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        occ32 = 32'(occ);
        occ8  = occ32 > 32'd255 ? 8'hff : occ32[7:0];
`ifdef JETSON_LINK_STATS_EN
        stats = err_cnt;
`else
        stats = 16'h0;
`endif
        cnt_word = {4'h0, occ8, 4'h0, stats};
        head     = mem[rd_ptr[FIFO_AW-1:0]];
        sel_n    = cnt_flag ? SEL_CNT : occ != 0 ? SEL_HEAD : SEL_NOP;
        word     = cnt_flag ? cnt_word : occ != 0 ? head : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {tx_id, tx_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_miso  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_id     <= 4'h0;
            rx_data   <= 28'h0;
            frame_err <= 1'b0;
            cnt_flag  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tx_ready  <= 1'b1;
            irq       <= 1'b0;
            bitcnt    <= 6'd0;
            sel       <= SEL_NOP;
            tx_sr     <= 32'h0;
            rx_sr     <= 32'h0;
        end else begin
            rx_valid  <= done_ok && rx_sr[31:28] != 4'h0;
            frame_err <= done_err;
            if (done_ok && rx_sr[31:28] != 4'h0) {rx_id, rx_data} <= rx_sr;
            // A new request arriving as the count frame completes wins over the clear.
            cnt_flag  <= req_edge | (cnt_flag & ~(done_ok && sel == SEL_CNT));
            wr_ptr    <= wr_ptr + (FIFO_AW+1)'(push);
            rd_ptr    <= rd_ptr + (FIFO_AW+1)'(pop);
            tx_ready  <= ~occ_n[FIFO_AW];
            irq       <= occ_n != 0;
            if (is_load) begin
                sel      <= sel_n;
                tx_sr    <= {word[30:0], 1'b0};
                spi_miso <= word[31];
                bitcnt   <= 6'd0;
            end else if (is_shift) begin
                if (sclk_rise) begin
                    rx_sr <= {rx_sr[30:0], s[2]};
                    if (~&bitcnt) bitcnt <= bitcnt + 6'd1;
                end
                if (sclk_fall) begin
                    spi_miso <= tx_sr[31];
                    tx_sr    <= {tx_sr[30:0], 1'b0};
                end
            end else begin
                spi_miso <= 1'b0;
            end
        end
    end

`ifdef JETSON_LINK_STATS_EN
    // Subtracting the snapshot keeps any errors counted after the count frame was loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt  <= 16'h0;
            err_snap <= 16'h0;
        end else begin
            if (is_load) err_snap <= err_cnt;
            if (done_err && err_cnt != 16'hffff) err_cnt <= err_cnt + 16'd1;
            else if (done_ok && sel == SEL_CNT) err_cnt <= err_cnt - err_snap;
        end
    end
`endif
endmodule

// File: tb/tb_jetson_spi_link.sv
// tb_jetson_spi_link: randomized scoreboard bench for jetson_spi_link acting as the Jetson SPI master.
module tb_jetson_spi_link;
    logic        clk = 0, rst = 1;
    logic        spi_sclk = 0, spi_mosi = 0, spi_cs_n = 1, cnt_req = 0;
    logic        spi_miso, irq, rx_valid, tx_ready, frame_err;
    logic [3:0]  rx_id, tx_id = 0;
    logic [27:0] rx_data, tx_data = 0;
    logic        tx_valid = 0;

    int checks = 0, failures = 0;
    logic [31:0] mq[$];
    logic [31:0] exp_rx[$], exp_miso[$], got_miso[$];
    int exp_err = 0;
    bit cflag = 0;
    int errs = 0;

    jetson_spi_link dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .cnt_req(cnt_req), .irq(irq), .rx_valid(rx_valid), .rx_id(rx_id),
        .rx_data(rx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id),
        .tx_data(tx_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, g, e, $time);
        end
    endtask

    function automatic logic [15:0] stats_m();
`ifdef JETSON_LINK_STATS_EN
        return 16'(errs);
`else
        return 16'h0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rx_valid) begin
            chk("rx_pending", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) chk("rx_word", {rx_id, rx_data}, exp_rx.pop_front());
        end
        if (frame_err) begin
            chk("frame_err_pending", exp_err > 0, 1);
            if (exp_err > 0) exp_err--;
        end
        while (got_miso.size() != 0 && exp_miso.size() != 0)
            chk("miso_word", got_miso.pop_front(), exp_miso.pop_front());
    end

    task automatic frame(input logic [31:0] w, input int nbits);
        logic [31:0] m, e, sh;
        int sel, o;
        m = 0;
        sh = w;
        o = mq.size();
        sel = cflag ? 2 : (o != 0 ? 1 : 0);
        e = sel == 2 ? {4'h0, 8'(o > 255 ? 255 : o), 4'h0, stats_m()} : sel == 1 ? mq[0] : 32'h0;
        spi_cs_n = 0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = sh[31];
            sh = sh << 1;
            #50 spi_sclk = 1;
            m = {m[30:0], spi_miso};
            #50 spi_sclk = 0;
        end
        #50;
        if (nbits == 32) begin
            exp_miso.push_back(e);
            got_miso.push_back(m);
            if (w[31:28] != 0) exp_rx.push_back(w);
            if (sel == 1) void'(mq.pop_front());
            if (sel == 2) begin
                cflag = 0;
                errs = 0;
            end
        end else begin
            exp_err++;
            if (errs < 65535) errs++;
        end
        spi_cs_n = 1;
        spi_mosi = 0;
        #100;
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        chk("tx_ready", tx_ready, mq.size() < 16);
        tx_valid = 1;
        {tx_id, tx_data} = w;
        @(posedge clk);
        #1 tx_valid = 0;
        if (mq.size() < 16) mq.push_back(w);
        chk("irq", irq, mq.size() != 0);
    endtask

    task automatic push_hold(input logic [31:0] w);
        bit ok = 0;
        @(negedge clk);
        tx_valid = 1;
        {tx_id, tx_data} = w;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                @(posedge clk);
                #1 tx_valid = 0;
                mq.push_back(w);
                ok = 1;
            end
        end
        tx_valid = 0;
        chk("push_hold_accepted", ok, 1);
    endtask

    task automatic toggle();
        cnt_req = ~cnt_req;
        cflag = 1;
        #40;
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (6) @(posedge clk);
        @(negedge clk) rst = 0;
        chk("rst_miso", spi_miso, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx", {rx_id, rx_data}, 0);
        chk("rst_frame_err", frame_err, 0);
        #100;
        frame(32'h0000_0000, 32);
        frame(32'hE000_0001, 32);
        push(32'h3002_0005);
        push(32'h5000_0096);
        frame(32'h0, 32);
        frame(32'h0, 32);
        chk("irq_drained", irq, 0);
        push(32'h1111_2222);
        push(32'h4333_4444);
        toggle();
        toggle();
        frame(32'h0, 32);
        frame(32'h0, 32);
        frame(32'h0, 32);
        push(32'h1500_0009);
        frame(32'h9ABC_DEF0, 17);
        frame(32'h0, 32);
        toggle();
        frame(32'h0, 32);
        toggle();
        frame(32'h0, 32);
        for (int i = 0; i < 17; i++) push(32'h2000_0000 + i);
        chk("tx_ready_full", tx_ready, 0);
        toggle();
        frame(32'h0, 32);
        fork
            frame(32'h6123_4567, 32);
            push_hold(32'h7000_00AA);
        join
        chk("tx_ready_refull", tx_ready, mq.size() < 16);
        while (mq.size() != 0) frame(32'h0, 32);
        chk("irq_empty", irq, 0);
        for (int k = 0; k < 60; k++) begin
            int r = $urandom_range(0, 9);
            if (r < 4) push($urandom);
            else if (r < 8) frame($urandom, 32);
            else if (r == 8) begin
                int n = $urandom_range(0, 39);
                frame($urandom, n >= 32 ? n + 1 : n);
            end else toggle();
        end
        toggle();
        frame(32'h0, 32);
        while (mq.size() != 0) frame($urandom, 32);
        #200;
        chk("rx_left", exp_rx.size(), 0);
        chk("err_left", exp_err, 0);
        chk("miso_left", exp_miso.size(), 0);
        chk("irq_final", irq, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
